// File: rtl/dmem_pixel_packer.sv
// Packs a stream of 8-bit grayscale pixels into 256-bit DMEM words, 32 pixels per word,
// and raises ccd_done toward the CPU once the last word of the frame has been written.
module dmem_pixel_packer #(
  parameter int unsigned NUM_PIXELS = 784,
  parameter logic [6:0]  BASE_ADDR  = 7'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         frame_start,
  input  logic         pxl_valid,
  input  logic [7:0]   pxl_data,
  output logic         ccd_done,
  output logic         dmem_wren,
  output logic [6:0]   dmem_wraddr,
  output logic [255:0] dmem_wrdata,
  output logic [9:0]   pxl_cnt
);

  localparam int unsigned WORD_W = 256;
  localparam int unsigned LANE_W = 5;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned IDX_W  = 13;

  localparam logic [IDX_W-1:0]  LAST_PIX  = IDX_W'(NUM_PIXELS - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_PACK  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [LANE_W-1:0]   r_lane;
  logic [ADDR_W-1:0]   r_word_idx;
  logic [IDX_W-1:0]    r_pix_idx;
  logic [WORD_W-1:0]   r_pack;
  logic                r_ccd_done;
  logic                r_wren;
  logic [ADDR_W-1:0]   r_wraddr;
  logic [WORD_W-1:0]   r_wrdata;
  logic [CNT_W-1:0]    r_pxl_cnt;

  logic [LANE_W-1:0]   w_lane_nxt;
  logic [ADDR_W-1:0]   w_word_idx_nxt;
  logic [IDX_W-1:0]    w_pix_idx_nxt;
  logic [WORD_W-1:0]   w_pack_nxt;
  logic                w_ccd_done_nxt;
  logic                w_wren_nxt;
  logic [ADDR_W-1:0]   w_wraddr_nxt;
  logic [WORD_W-1:0]   w_wrdata_nxt;
  logic [CNT_W-1:0]    w_pxl_cnt_nxt;

  logic                w_restart;
  logic                w_accept;
  logic                w_last_pix;
  logic                w_word_full;
  logic [WORD_W-1:0]   w_merged;

  // frame_start outranks a coincident pixel; dropping enable outranks both
  assign w_restart   = enable && frame_start && ((r_state == S_ARMED) || (r_state == S_PACK));
  assign w_accept    = enable && !frame_start && pxl_valid && (r_state == S_PACK);
  assign w_last_pix  = w_accept && (r_pix_idx == LAST_PIX);
  assign w_word_full = w_accept && ((r_lane == LAST_LANE) || (r_pix_idx == LAST_PIX));

  // Current pack register with the incoming pixel dropped into its lane
  always_comb begin
    w_merged = r_pack;
    w_merged[{r_lane, 3'b000} +: 8] = pxl_data;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!enable)          w_state_nxt = S_IDLE;
        else if (frame_start) w_state_nxt = S_PACK;
      end
      S_PACK: begin
        if (!enable)          w_state_nxt = S_IDLE;
        else if (frame_start) w_state_nxt = S_PACK;
        else if (w_last_pix)  w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!enable) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the datapath and output registers
  always_comb begin
    w_lane_nxt     = r_lane;
    w_word_idx_nxt = r_word_idx;
    w_pix_idx_nxt  = r_pix_idx;
    w_pack_nxt     = r_pack;
    w_pxl_cnt_nxt  = r_pxl_cnt;
    w_wren_nxt     = 1'b0;
    w_wraddr_nxt   = r_wraddr;
    w_wrdata_nxt   = r_wrdata;
    w_ccd_done_nxt = (r_state == S_DONE) && enable;

    if (w_restart) begin
      w_lane_nxt     = '0;
      w_word_idx_nxt = '0;
      w_pix_idx_nxt  = '0;
      w_pack_nxt     = '0;
      w_pxl_cnt_nxt  = '0;
    end else if (w_accept) begin
      w_pix_idx_nxt = r_pix_idx + IDX_W'(1);
      if (r_pxl_cnt != CNT_MAX) w_pxl_cnt_nxt = r_pxl_cnt + CNT_W'(1);
      if (w_word_full) begin
        // Flush the word; the pack register is free for a pixel in the very next cycle
        w_wren_nxt     = 1'b1;
        w_wraddr_nxt   = BASE_ADDR + r_word_idx;
        w_wrdata_nxt   = w_merged;
        w_pack_nxt     = '0;
        w_lane_nxt     = '0;
        w_word_idx_nxt = r_word_idx + ADDR_W'(1);
      end else begin
        w_pack_nxt = w_merged;
        w_lane_nxt = r_lane + LANE_W'(1);
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane     <= '0;
      r_word_idx <= '0;
      r_pix_idx  <= '0;
      r_pack     <= '0;
      r_ccd_done <= 1'b0;
      r_wren     <= 1'b0;
      r_wraddr   <= '0;
      r_wrdata   <= '0;
      r_pxl_cnt  <= '0;
    end else begin
      r_lane     <= w_lane_nxt;
      r_word_idx <= w_word_idx_nxt;
      r_pix_idx  <= w_pix_idx_nxt;
      r_pack     <= w_pack_nxt;
      r_ccd_done <= w_ccd_done_nxt;
      r_wren     <= w_wren_nxt;
      r_wraddr   <= w_wraddr_nxt;
      r_wrdata   <= w_wrdata_nxt;
      r_pxl_cnt  <= w_pxl_cnt_nxt;
    end
  end

  assign ccd_done    = r_ccd_done;
  assign dmem_wren   = r_wren;
  assign dmem_wraddr = r_wraddr;
  assign dmem_wrdata = r_wrdata;
  assign pxl_cnt     = r_pxl_cnt;

endmodule

// File: doc/dmem_pixel_packer.md
Name: dmem_pixel_packer

Overview:
- Downstream of the D5M capture/downscale path in Image_Proc.
- Consumes a stream of 8-bit grayscale pixels for one NN input frame (default 28x28).
- Packs 32 pixels into each 256-bit word and writes the words into DMEM through the dmem_wren/dmem_wraddr/dmem_wrdata port.
- Signals frame completion to the CPU with the enable/ccd_done handshake.

Parameters:
NUM_PIXELS, 784, pixels per frame; range 1..4096.
BASE_ADDR, 0, first DMEM word address; 7-bit value.

Ports:
clk  input  1  system clock (CLOCK_50 domain).
rst_n  input  1  asynchronous active-low reset.
enable  input  1  CPU request to capture one frame; level, held high until ccd_done is seen.
frame_start  input  1  one-cycle pulse at start of a downscaled frame.
pxl_valid  input  1  pxl_data valid this cycle.
pxl_data  input  8  grayscale pixel.
ccd_done  output  1  frame fully written to DMEM.
dmem_wren  output  1  DMEM write strobe, one cycle per word.
dmem_wraddr  output  7  DMEM word address.
dmem_wrdata  output  256  packed pixel word.
pxl_cnt  output  10  debug: pixels accepted in current frame; saturates at 1023.

Behaviour:
- Reset (async, rst_n=0): state IDLE. ccd_done=0, dmem_wren=0, dmem_wraddr=0, dmem_wrdata=0, pxl_cnt=0, lane=0, word_idx=0, pack register=0.
- Registered outputs: all outputs are registered. No combinational path from any input to any output.
- State IDLE:
  - enable=1 -> ARMED.
  - Pixels and frame_start are ignored.
- State ARMED:
  - frame_start=1 -> PACK. Clear pxl_cnt, lane, word_idx and the pack register.
  - pxl_valid is ignored.
- State PACK, each cycle with pxl_valid=1:
  - pxl_data is written into byte lane `lane` (bits [8*lane+7 : 8*lane]). Pixel 0 of each word is in bits [7:0].
  - lane and pxl_cnt each increment.
- Word write:
  - Triggered when the accepted pixel fills lane 31 or is pixel NUM_PIXELS-1.
  - On the next cycle: dmem_wren=1 for exactly one cycle, dmem_wraddr=(BASE_ADDR+word_idx) mod 128, dmem_wrdata=packed word.
  - Unfilled lanes are 0.
  - lane and the pack register clear, and word_idx increments.
  - A pixel arriving in the cycle the write is issued is accepted into lane 0 of the next word. Throughput is 1 pixel/cycle with no stall.
- Frame end:
  - After the write of the final pixel's word -> DONE.
  - Number of words = ceil(NUM_PIXELS/32). The default gives 25 words; the last word holds 16 pixels.
- State DONE:
  - ccd_done=1, asserted the cycle after the final dmem_wren.
  - ccd_done holds while enable=1.
  - enable=0 -> IDLE, ccd_done=0 next cycle.
- frame_start while in PACK: abort the partial frame with no write of the partial word. Restart the count from 0 with word_idx=0 (same transitions as ARMED).
- enable=0 while in ARMED or PACK: -> IDLE. Any partial word is discarded and no write is issued. A write already scheduled for this cycle still completes.
- pxl_valid and frame_start in the same cycle: frame_start wins and the pixel is discarded.
- Address overflow: BASE_ADDR+word_idx wraps modulo 128. No error is flagged.
- pxl_valid in IDLE, ARMED or DONE: no effect on any output.

Test Plan:
- Nominal frame:
  - Stimulus: enable=1, frame_start, then 784 back-to-back pixels with value i[7:0].
  - Expected: exactly 25 wren pulses at addresses 0..24.
  - Word 0 = bytes 0x00..0x1F ascending from bit 0.
  - Word 24 lanes 0..15 = 0x00..0x0F and lanes 16..31 = 0.
  - ccd_done rises 1 cycle after the 25th wren.
  - enable=0 then drops ccd_done next cycle.
- Gapped stream:
  - Stimulus: pxl_valid random 50% duty, same data.
  - Expected: identical DMEM contents and order as the nominal frame.
  - Each wren occurs exactly 1 cycle after the 32nd pixel of its word is accepted.
- Abort/restart:
  - Stimulus: frame_start after 40 pixels, then a full 784-pixel frame of value 0xAA.
  - Expected: first frame produces one write (addr 0, all 0x00..0x1F); the partial second word is never written.
  - Second frame writes addresses 0..24 with all bytes 0xAA, then ccd_done.
- Enable drop and async reset mid-frame:
  - Stimulus: enable=0 after 100 pixels.
  - Expected: 3 writes then none; state IDLE; ccd_done stays 0.
  - Stimulus: separately, rst_n=0 asynchronously mid-word.
  - Expected: all outputs 0 immediately, without waiting for a clk edge.
- Parameter edge:
  - Stimulus: BASE_ADDR=120, NUM_PIXELS=300.
  - Expected: 10 writes at addresses 120..127, 0, 1.
  - Last word has 12 valid lanes and the rest 0.
- Ignored inputs:
  - Stimulus: pxl_valid pulses in IDLE/ARMED/DONE, and frame_start coincident with pxl_valid.
  - Expected: no wren, pxl_cnt unchanged, and the coincident pixel is not counted.
